// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types and constants for the LEGv8 write-back slice.
package legv8_pkg;
  localparam logic [4:0] XZR = 5'd31;
  localparam int DATA_W = 64;
  typedef logic [1:0] pend_t;
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              kill;
    logic [4:0]        wa;
    logic [DATA_W-1:0] data;
  } mem_wb_t;
endpackage

// File: rtl/mux2.sv
// mux2: two-input select of width W.
module mux2 #(parameter int W = 64) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/pend_counter.sv
// pend_counter: 2-bit outstanding-write counter, saturating at 3 and holding at 0.
import legv8_pkg::*;
module pend_counter (
  input  logic  clk,
  input  logic  reset,
  input  logic  inc,
  input  logic  dec,
  output pend_t cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (inc && !dec && cnt != 2'd3) cnt <= cnt + 2'd1;
    else if (dec && !inc && cnt != 2'd0) cnt <= cnt - 2'd1;
  underflow: assert property (@(posedge clk) disable iff (reset) !(dec && !inc && cnt == 2'd0));
endmodule

// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard: MEM/WB register, register-file write port and per-register
// pending-write scoreboard that stalls decode on read-after-write hazards.
import legv8_pkg::*;
module writeback_scoreboard #(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         issue_valid,
  input  logic         issue_regWrite,
  input  logic [4:0]   issue_wa,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic         stall_D,
  input  logic         valid_M,
  input  logic         regWrite_M,
  input  logic         kill_M,
  input  logic         memtoReg_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] readData_M,
  input  logic [4:0]   wa3_M,
  output logic         regWrite_D,
  output logic [4:0]   wa3_D,
  output logic [N-1:0] writeData3_D
);
  mem_wb_t      wb;
  logic [N-1:0] result_M;
  pend_t        pend [NREG];
  logic         issue_try, accept, retire;
  mux2 #(.W(N)) u_mux (.d0(aluResult_M), .d1(readData_M), .s(memtoReg_M), .y(result_M));
  always_ff @(posedge clk or posedge reset)
    if (reset) wb <= '0;
    else wb <= '{valid: valid_M, reg_write: regWrite_M, kill: kill_M, wa: wa3_M, data: DATA_W'(result_M)};
  // Killed entries still retire so the scoreboard drains; only the file write is dropped.
  assign retire       = wb.valid && wb.reg_write && wb.wa != XZR;
  assign regWrite_D   = retire && !wb.kill;
  assign wa3_D        = wb.wa;
  assign writeData3_D = wb.data[N-1:0];
  assign issue_try = issue_valid && issue_regWrite && issue_wa != XZR;
  assign accept    = issue_try && !stall_D;
  assign stall_D   = (ra1 != XZR && pend[ra1] != 2'd0) ||
                     (ra2 != XZR && pend[ra2] != 2'd0) ||
                     (issue_try && pend[issue_wa] == 2'd3);
  assign pend[NREG-1] = '0;
  for (genvar i = 0; i < NREG - 1; i++) begin : g_pend
    pend_counter u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (accept && issue_wa == 5'(i)),
      .dec  (retire && wb.wa == 5'(i)),
      .cnt  (pend[i])
    );
  end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// tb_writeback_scoreboard: directed checks of the write port and hazard scoreboard.
module tb_writeback_scoreboard;
  logic        clk = 0, reset = 1;
  logic        issue_valid = 0, issue_regWrite = 0;
  logic [4:0]  issue_wa = 0, ra1 = 0, ra2 = 0, wa3_M = 0;
  logic        valid_M = 0, regWrite_M = 0, kill_M = 0, memtoReg_M = 0;
  logic [63:0] aluResult_M = 0, readData_M = 0;
  logic        stall_D, regWrite_D;
  logic [4:0]  wa3_D;
  logic [63:0] writeData3_D;
  int checks = 0, errors = 0;

  writeback_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_regWrite(issue_regWrite),
    .issue_wa(issue_wa), .ra1(ra1), .ra2(ra2), .stall_D(stall_D), .valid_M(valid_M),
    .regWrite_M(regWrite_M), .kill_M(kill_M), .memtoReg_M(memtoReg_M),
    .aluResult_M(aluResult_M), .readData_M(readData_M), .wa3_M(wa3_M),
    .regWrite_D(regWrite_D), .wa3_D(wa3_D), .writeData3_D(writeData3_D)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] wa);
    issue_valid = 1; issue_regWrite = 1; issue_wa = wa;
  endtask

  task automatic no_issue;
    issue_valid = 0; issue_regWrite = 0; issue_wa = 0;
  endtask

  task automatic mem(input logic [4:0] wa, input logic kill, input logic ld,
                     input logic [63:0] alu, input logic [63:0] rd);
    valid_M = 1; regWrite_M = 1; wa3_M = wa; kill_M = kill; memtoReg_M = ld;
    aluResult_M = alu; readData_M = rd;
  endtask

  task automatic no_mem;
    valid_M = 0; regWrite_M = 0; wa3_M = 0; kill_M = 0; memtoReg_M = 0;
    aluResult_M = 0; readData_M = 0;
  endtask

  initial begin
    // reset state
    tick; tick;
    chk("rst_regwrite", regWrite_D, 0);
    chk("rst_wa3", wa3_D, 0);
    chk("rst_wdata", writeData3_D, 0);
    chk("rst_stall", stall_D, 0);
    reset = 0;
    tick;

    // issue X5, reader waits, X5 leaves MEM with 0x1234
    issue(5); #1;
    chk("x5_issue_nostall", stall_D, 0);
    tick; no_issue; ra1 = 5; #1;
    chk("x5_stall_a", stall_D, 1);
    tick; #1;
    chk("x5_stall_b", stall_D, 1);
    mem(5, 0, 0, 64'h1234, 64'h0);
    tick; no_mem; #1;
    chk("x5_we", regWrite_D, 1);
    chk("x5_wa", wa3_D, 5);
    chk("x5_wdata", writeData3_D, 64'h1234);
    chk("x5_stall_c", stall_D, 1);
    tick; #1;
    chk("x5_we_off", regWrite_D, 0);
    chk("x5_released", stall_D, 0);
    ra1 = 0;

    // load to X9 selects readData
    issue(9); tick; no_issue;
    mem(9, 0, 1, 64'h40, 64'hDEAD);
    tick; no_mem; #1;
    chk("x9_we", regWrite_D, 1);
    chk("x9_wa", wa3_D, 9);
    chk("x9_wdata", writeData3_D, 64'hDEAD);
    tick; ra1 = 9; #1;
    chk("x9_drained", stall_D, 0);
    ra1 = 0;

    // same-cycle issue and retire of X7 keeps pend[7] at 1
    issue(7); tick; no_issue;
    mem(7, 0, 0, 64'h77, 64'h0);
    tick; no_mem;
    issue(7); #1;
    chk("x7_issue_ok", stall_D, 0);
    tick; no_issue; ra2 = 7; #1;
    chk("x7_still_pending", stall_D, 1);
    mem(7, 0, 0, 64'h78, 64'h0);
    tick; no_mem; tick; #1;
    chk("x7_drained", stall_D, 0);
    ra2 = 0;

    // killed retire of X3
    issue(3); tick; no_issue; ra1 = 3; #1;
    chk("x3_stall", stall_D, 1);
    mem(3, 1, 0, 64'h33, 64'h0);
    tick; no_mem; #1;
    chk("x3_kill_we", regWrite_D, 0);
    chk("x3_kill_wa", wa3_D, 3);
    chk("x3_stall_b", stall_D, 1);
    tick; #1;
    chk("x3_released", stall_D, 0);
    ra1 = 0;

    // XZR destination never pends nor writes
    issue(31); #1;
    chk("x31_issue_nostall", stall_D, 0);
    tick; no_issue; ra1 = 31; ra2 = 31; #1;
    chk("x31_read_nostall", stall_D, 0);
    mem(31, 0, 0, 64'h31, 64'h0);
    tick; no_mem; #1;
    chk("x31_we", regWrite_D, 0);
    chk("x31_wa", wa3_D, 31);
    tick; #1;
    chk("x31_after", stall_D, 0);
    ra1 = 0; ra2 = 0;

    // saturation at 3 on X2
    for (int i = 0; i < 3; i++) begin
      issue(2); #1;
      chk("x2_issue_ok", stall_D, 0);
      tick;
    end
    issue(2); #1;
    chk("x2_fourth_stall", stall_D, 1);
    tick; no_issue;
    mem(2, 0, 0, 64'h2, 64'h0);
    tick; tick; tick; no_mem; ra1 = 2; #1;
    chk("x2_one_left", stall_D, 1);
    tick; #1;
    chk("x2_drained", stall_D, 0);
    ra1 = 0;

    // asynchronous reset with pend[5] = 2 and an entry on the write port
    issue(5); tick; tick; no_issue;
    mem(5, 0, 0, 64'h55, 64'h0);
    tick; no_mem; ra1 = 5; #1;
    chk("rst2_pre_we", regWrite_D, 1);
    chk("rst2_pre_stall", stall_D, 1);
    reset = 1; #1;
    chk("rst2_async_we", regWrite_D, 0);
    chk("rst2_async_wa", wa3_D, 0);
    chk("rst2_async_wdata", writeData3_D, 0);
    chk("rst2_async_stall", stall_D, 0);
    tick; tick; reset = 0; tick; #1;
    chk("rst2_after_stall", stall_D, 0);
    chk("rst2_after_we", regWrite_D, 0);
    ra1 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
